// File: rtl/mix_dac_spi.sv
// Four-channel audio mixer that ships one mode-0 SPI DAC frame per sample period.
// Each frame: W data bits MSB first, a chip-select tail, a gap, then an LDAC latch pulse.
module mix_dac_spi #(
    parameter int N          = 11,
    parameter int SAMPLE_DIV = 250,
    parameter int H          = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] ch0,
    input  logic [N-1:0] ch1,
    input  logic [N-1:0] ch2,
    input  logic [N-1:0] ch3,
    output logic         dac_cs_n,
    output logic         dac_sclk,
    output logic         dac_mosi,
    output logic         dac_ldac_n,
    output logic [N:0]   mix_out,
    output logic         busy,
    output logic         overrun
);

    localparam int W  = N + 5;
    localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int BW = $clog2(W);

    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H - 1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(W - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT_LO = 3'd1;
    localparam logic [2:0] S_SHIFT_HI = 3'd2;
    localparam logic [2:0] S_TAIL     = 3'd3;
    localparam logic [2:0] S_GAP      = 3'd4;
    localparam logic [2:0] S_LDAC     = 3'd5;

    logic [2:0]    state_q,   state_d;
    logic [DW-1:0] div_q,     div_d;
    logic [HW-1:0] hcnt_q,    hcnt_d;
    logic [BW-1:0] bit_q,     bit_d;
    logic [W-1:0]  word_q,    word_d;
    logic [N:0]    mix_q,     mix_d;
    logic          cs_n_q,    cs_n_d;
    logic          sclk_q,    sclk_d;
    logic          mosi_q,    mosi_d;
    logic          ldac_n_q,  ldac_n_d;
    logic          busy_q,    busy_d;
    logic          overrun_q, overrun_d;

    logic          tick_s;
    logic          hdone_s;
    logic [N+1:0]  sum_s;
    logic [N:0]    mix_s;
    logic [W-1:0]  word_s;

    assign tick_s  = (div_q == DIV_LAST);
    assign hdone_s = (hcnt_q == H_LAST);

    // Four N-bit samples fit in N+2 bits; halving keeps the mix within N+1 bits.
    assign sum_s  = {2'b00, ch0} + {2'b00, ch1} + {2'b00, ch2} + {2'b00, ch3};
    assign mix_s  = (N + 1)'(sum_s >> 1);
    assign word_s = {4'b0111, mix_s};

    // Next-state logic for the sample timer and the SPI/LDAC frame sequencer.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        bit_d     = bit_q;
        word_d    = word_q;
        mix_d     = mix_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ldac_n_d  = ldac_n_q;
        busy_d    = busy_q;

        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end

        if (tick_s && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_s) begin
                    word_d  = word_s;
                    mix_d   = mix_s;
                    cs_n_d  = 1'b0;
                    mosi_d  = word_s[W-1];
                    bit_d   = BIT_TOP;
                    busy_d  = 1'b1;
                    hcnt_d  = '0;
                    state_d = S_SHIFT_LO;
                end else begin
                    hcnt_d = '0;
                end
            end
            S_SHIFT_LO: begin
                if (hdone_s) begin
                    sclk_d  = 1'b1;
                    hcnt_d  = '0;
                    state_d = S_SHIFT_HI;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_SHIFT_HI: begin
                if (hdone_s) begin
                    sclk_d = 1'b0;
                    hcnt_d = '0;
                    if (bit_q == '0) begin
                        state_d = S_TAIL;
                    end else begin
                        // Rotate so the next bit sits at the top; mosi only moves on this falling edge.
                        bit_d   = bit_q - BW'(1);
                        word_d  = {word_q[W-2:0], word_q[W-1]};
                        mosi_d  = word_q[W-2];
                        state_d = S_SHIFT_LO;
                    end
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_TAIL: begin
                if (hdone_s) begin
                    cs_n_d  = 1'b1;
                    hcnt_d  = '0;
                    state_d = S_GAP;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_GAP: begin
                if (hdone_s) begin
                    ldac_n_d = 1'b0;
                    hcnt_d   = '0;
                    state_d  = S_LDAC;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            S_LDAC: begin
                if (hdone_s) begin
                    ldac_n_d = 1'b1;
                    busy_d   = 1'b0;
                    hcnt_d   = '0;
                    state_d  = S_IDLE;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                hcnt_d   = '0;
                cs_n_d   = 1'b1;
                sclk_d   = 1'b0;
                ldac_n_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            hcnt_q    <= '0;
            bit_q     <= '0;
            word_q    <= '0;
            mix_q     <= '0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            hcnt_q    <= hcnt_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            mix_q     <= mix_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ldac_n_q  <= ldac_n_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;
    assign dac_ldac_n = ldac_n_q;
    assign mix_out    = mix_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
